// File: rtl/bit_splitter_sipo_if.sv
// Bus bundle for bit_splitter_sipo: serial bit input, frame control and per-lane word handshake.
// The master side drives the stream and acks; the slave side is the splitter.
interface bit_splitter_sipo_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 4
);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      bit_in;
  logic                      bit_valid;
  logic                      sync;
  logic                      msb_first;
  logic [CHANNELS-1:0]       word_ack;
  logic [CHANNELS*WIDTH-1:0] word_out;
  logic [CHANNELS-1:0]       word_valid;
  logic [CHANNELS-1:0]       overrun;
  logic [IDX_W-1:0]          ch_idx;

  modport master (
    output bit_in,
    output bit_valid,
    output sync,
    output msb_first,
    output word_ack,
    input  word_out,
    input  word_valid,
    input  overrun,
    input  ch_idx
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    input  sync,
    input  msb_first,
    input  word_ack,
    output word_out,
    output word_valid,
    output overrun,
    output ch_idx
  );
endinterface

// File: rtl/bit_splitter_sipo.sv
// Round-robin serial-to-parallel splitter: deals a bit stream across CHANNELS lanes,
// each lane assembling WIDTH-bit words presented with a valid/ack handshake and sticky overrun.
module bit_splitter_sipo #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 4
) (
  input logic               clk,
  input logic               reset,
  bit_splitter_sipo_if.slave bus
);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic                      mode_q;
  logic                      mode_eff;
  logic [IDX_W-1:0]          ch_idx_q;
  logic [IDX_W-1:0]          ch_idx_nxt;
  logic [IDX_W-1:0]          tgt;
  logic [CHANNELS*WIDTH-1:0] word_flat;
  logic [CHANNELS-1:0]       valid_flat;
  logic [CHANNELS-1:0]       ovr_flat;

  // A sync on the same edge as a bit makes that bit land in lane 0 under the new mode.
  always_comb begin
    tgt      = bus.sync ? '0 : ch_idx_q;
    mode_eff = bus.sync ? bus.msb_first : mode_q;
    if (!bus.bit_valid) begin
      ch_idx_nxt = tgt;
    end else if (tgt == LAST_CH) begin
      ch_idx_nxt = '0;
    end else begin
      ch_idx_nxt = tgt + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= 1'b0;
      ch_idx_q <= '0;
    end else begin
      if (bus.sync) begin
        mode_q <= bus.msb_first;
      end
      ch_idx_q <= ch_idx_nxt;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] base_cnt;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] base_sr;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic             ovr_q;
    logic             hit;
    logic             done;
    logic             ack;

    // The completing bit is folded in combinationally so the word is published on its own edge.
    always_comb begin
      base_cnt = bus.sync ? '0 : cnt_q;
      base_sr  = bus.sync ? '0 : sr_q;
      hit      = bus.bit_valid && (tgt == IDX_W'(k));
      done     = hit && (base_cnt == LAST_CNT);
      ack      = bus.word_ack[k];
      if (mode_eff) begin
        shifted = {base_sr[WIDTH-2:0], bus.bit_in};
      end else begin
        shifted = {bus.bit_in, base_sr[WIDTH-1:1]};
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q   <= '0;
        sr_q    <= '0;
        word_q  <= '0;
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        if (hit) begin
          sr_q  <= shifted;
          cnt_q <= done ? '0 : base_cnt + CNT_W'(1);
        end else if (bus.sync) begin
          sr_q  <= '0;
          cnt_q <= '0;
        end
        // A same-edge ack consumes the old word, so only an unacked overwrite is an overrun.
        if (done) begin
          word_q  <= shifted;
          valid_q <= 1'b1;
          if (valid_q && !ack) begin
            ovr_q <= 1'b1;
          end
        end else if (ack) begin
          valid_q <= 1'b0;
        end
      end
    end

    assign word_flat[k*WIDTH +: WIDTH] = word_q;
    assign valid_flat[k]               = valid_q;
    assign ovr_flat[k]                 = ovr_q;
  end

  assign bus.word_out   = word_flat;
  assign bus.word_valid = valid_flat;
  assign bus.overrun    = ovr_flat;
  assign bus.ch_idx     = ch_idx_q;
endmodule

// File: tb/tb_bit_splitter_sipo.sv
// Directed bench for bit_splitter_sipo (2 lanes x 4 bits) with a behavioural lane model and
// a queue of expected completed words checked on the edge each word is produced.
module tb_bit_splitter_sipo;
  localparam int CHANNELS = 2;
  localparam int WIDTH    = 4;

  typedef struct {
    int               lane;
    logic [WIDTH-1:0] word;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bit_splitter_sipo_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) bus ();

  bit_splitter_sipo #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  int                  m_idx;
  int                  m_cnt [CHANNELS];
  logic [WIDTH-1:0]    m_acc [CHANNELS];
  logic [WIDTH-1:0]    m_word[CHANNELS];
  logic                m_mode;
  logic [CHANNELS-1:0] m_valid;
  logic [CHANNELS-1:0] m_ovr;
  logic [0:7]          stream = 8'b10110010;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_idx   = 0;
    m_mode  = 1'b0;
    m_valid = '0;
    m_ovr   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      m_cnt[k]  = 0;
      m_acc[k]  = '0;
      m_word[k] = '0;
    end
    sbq.delete();
  endtask

  task automatic verifyState();
    exp_t                      e;
    logic [CHANNELS*WIDTH-1:0] flat;
    for (int k = 0; k < CHANNELS; k++) flat[k*WIDTH +: WIDTH] = m_word[k];
    checkOutput("word_valid", bus.word_valid, m_valid);
    checkOutput("overrun", bus.overrun, m_ovr);
    checkOutput("ch_idx", bus.ch_idx, m_idx);
    checkOutput("word_out", bus.word_out, flat);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput($sformatf("completed lane%0d", e.lane),
                  bus.word_out[e.lane*WIDTH +: WIDTH], e.word);
    end
  endtask

  // Updates the model, drives one cycle of inputs, then checks just after the edge.
  task automatic applyStimulus(input logic b, input logic v, input logic s, input logic msb,
                               input logic [CHANNELS-1:0] ack);
    logic [CHANNELS-1:0] done;
    exp_t                e;
    int                  lane;
    int                  pos;
    done = '0;
    if (s) begin
      for (int k = 0; k < CHANNELS; k++) begin
        m_cnt[k] = 0;
        m_acc[k] = '0;
      end
      m_mode = msb;
      m_idx  = 0;
    end
    if (v) begin
      lane              = m_idx;
      pos               = m_mode ? (WIDTH - 1 - m_cnt[lane]) : m_cnt[lane];
      m_acc[lane][pos]  = b;
      m_cnt[lane]++;
      if (m_cnt[lane] == WIDTH) begin
        done[lane]  = 1'b1;
        m_cnt[lane] = 0;
        e.lane = lane;
        e.word = m_acc[lane];
        sbq.push_back(e);
      end
      m_idx = (m_idx + 1) % CHANNELS;
    end
    for (int k = 0; k < CHANNELS; k++) begin
      if (done[k]) begin
        if (m_valid[k] && !ack[k]) m_ovr[k] = 1'b1;
        m_valid[k] = 1'b1;
        m_word[k]  = m_acc[k];
        m_acc[k]   = '0;
      end else if (ack[k]) begin
        m_valid[k] = 1'b0;
      end
    end
    bus.bit_in    = b;
    bus.bit_valid = v;
    bus.sync      = s;
    bus.msb_first = msb;
    bus.word_ack  = ack;
    @(posedge clk);
    #1;
    bus.bit_valid = 1'b0;
    bus.sync      = 1'b0;
    bus.word_ack  = '0;
    verifyState();
  endtask

  task automatic sendFrame(input bit gaps, input bit ackDone);
    logic [CHANNELS-1:0] ack;
    for (int i = 0; i < 8; i++) begin
      ack = '0;
      if (ackDone && i == 6) ack = 2'b01;
      if (ackDone && i == 7) ack = 2'b10;
      applyStimulus(stream[i], 1'b1, 1'b0, 1'b0, ack);
      if (gaps) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.sync      = 1'b0;
    bus.msb_first = 1'b0;
    bus.word_ack  = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset word_valid", bus.word_valid, 2'b00);
    checkOutput("reset overrun", bus.overrun, 2'b00);
    checkOutput("reset ch_idx", bus.ch_idx, 0);
    checkOutput("reset word_out", bus.word_out, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] LSB-first frame");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
    sendFrame(1'b0, 1'b0);
    checkOutput("lsb lane0", bus.word_out[3:0], 4'hB);
    checkOutput("lsb lane1", bus.word_out[7:4], 4'h2);
    checkOutput("lsb valid", bus.word_valid, 2'b11);

    $display("[TB] MSB-first frame");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);
    sendFrame(1'b0, 1'b0);
    checkOutput("msb lane0", bus.word_out[3:0], 4'hD);
    checkOutput("msb lane1", bus.word_out[7:4], 4'h4);
    checkOutput("msb overrun", bus.overrun, 2'b00);

    $display("[TB] gapped frame and single-lane ack");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
    sendFrame(1'b1, 1'b0);
    checkOutput("gap words", bus.word_out, 8'h2B);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    checkOutput("ack valid", bus.word_valid, 2'b10);
    checkOutput("ack word_out held", bus.word_out, 8'h2B);

    $display("[TB] overrun");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    sendFrame(1'b0, 1'b0);
    sendFrame(1'b0, 1'b0);
    checkOutput("overrun set", bus.overrun, 2'b11);
    checkOutput("overrun words", bus.word_out, 8'h2B);
    doReset();
    sendFrame(1'b0, 1'b1);
    sendFrame(1'b0, 1'b1);
    checkOutput("acked no overrun", bus.overrun, 2'b00);

    $display("[TB] mid-word sync");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("sync ch_idx", bus.ch_idx, 1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("sync lane0", bus.word_out[3:0], 4'h1);
    checkOutput("sync lane1", bus.word_out[7:4], 4'h0);
    checkOutput("sync valid", bus.word_valid, 2'b11);

    $display("[TB] asynchronous reset");
    @(posedge clk);
    #3;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("async word_valid", bus.word_valid, 2'b00);
    checkOutput("async word_out", bus.word_out, 8'h00);
    checkOutput("async overrun", bus.overrun, 2'b00);
    checkOutput("async ch_idx", bus.ch_idx, 0);
    @(negedge clk);
    reset = 1'b1;
    sendFrame(1'b0, 1'b0);
    checkOutput("post-reset words", bus.word_out, 8'h2B);
    checkOutput("post-reset valid", bus.word_valid, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit_splitter_sipo.md
Name: bit_splitter_sipo

Overview:
Parametrised round-robin serial-to-parallel splitter. A single serial bit stream is dealt bit-by-bit across CHANNELS lanes, and each lane assembles a WIDTH-bit word. A completed word is presented with a per-lane valid/ack handshake and overrun flagging. It generalises the two-lane even/odd 4-bit splitter in the bit-splitter datapath:
- internal channel sequencing replaces the external toggle input;
- bit order is selectable;
- frame sync is added.

Parameters:
CHANNELS, 2, number of output lanes (>=1).
WIDTH, 4, bits per assembled word (>=2).
IDX_W, max(1,clog2(CHANNELS)), derived; width of ch_idx. Not user-set.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset. 0 = reset asserted.
bit_in  in  1  serial data bit.
bit_valid  in  1  bit_in is accepted on this rising edge.
sync  in  1  frame restart: clears partial words, returns sequencing to lane 0, latches msb_first.
msb_first  in  1  bit order, sampled only while sync=1. 0 = first bit lands in word bit 0.
word_ack  in  CHANNELS  per-lane consume strobe for word_valid.
word_out  out  CHANNELS*WIDTH  lane k word at [k*WIDTH +: WIDTH].
word_valid  out  CHANNELS  per-lane word-available flag (level).
overrun  out  CHANNELS  sticky: lane completed a word while its word_valid was still set and not acked.
ch_idx  out  IDX_W  lane that will receive the next accepted bit.

Behaviour:
Reset (reset=0, asynchronous):
- Clears ch_idx, all shift registers, all per-lane bit counters, word_out, word_valid and overrun.
- Clears the mode register (LSB-first).
- No bit is accepted while reset=0.

Sequencing:
- Each accepted bit (bit_valid=1) goes to lane ch_idx.
- ch_idx then advances by 1, wrapping CHANNELS-1 -> 0.
- bit_valid=0 holds all state; idle gaps of any length are allowed.

Per-lane assembly:
- Each lane has a counter cnt 0..WIDTH-1 and a shift register sr.
- LSB-first: sr shifts right with the new bit inserted at bit WIDTH-1.
- MSB-first: sr shifts left with the new bit inserted at bit 0.
- When the accepted bit has cnt==WIDTH-1:
  - The complete word, including this bit, is written to the word_out slice on that same edge.
  - cnt wraps to 0 and word_valid[k] is set.
- Latency is 0 cycles after the final bit's accepting edge; the word is visible from that edge onward.

Output handshake:
- word_out slice and word_valid[k] hold until word_ack[k] or the next completion for lane k.
- word_ack[k]=1 with no completion on that edge clears word_valid[k]. word_out holds its value.
- Completion with word_valid[k]=1 and word_ack[k]=0: the word is overwritten, word_valid stays 1, overrun[k] is set. overrun clears only on reset.
- Completion and word_ack[k] on the same edge: the new word is loaded, word_valid stays 1, no overrun.
- word_ack on a lane whose word_valid=0 is ignored.

Sync:
- sync=1 clears all cnt and sr, loads the mode register from msb_first, and forces ch_idx to 0.
- If bit_valid=1 on the same edge, that bit is accepted as bit 0 of lane 0 in the newly latched mode, and ch_idx becomes 1 mod CHANNELS.
- word_out, word_valid and overrun are not affected by sync.

CHANNELS=1:
- ch_idx is constantly 0 and every bit goes to lane 0.

Test Plan:
- LSB-first, C=2/W=4: after sync (msb_first=0), stream 1,0,1,1,0,0,1,0 with bit_valid=1 -> ch_idx alternates 0,1; on the 7th edge word_out[3:0]=4'hB and word_valid=2'b01; on the 8th edge word_out[7:4]=4'h2 and word_valid=2'b11.
- MSB-first: same stream after sync with msb_first=1 -> lane0=4'hD, lane1=4'h4; overrun=0.
- Gaps and ack: same stream with bit_valid deasserted every other cycle -> identical words. word_ack=2'b01 one cycle -> word_valid=2'b10 and word_out unchanged.
- Overrun: 16 bits without ack -> overrun=2'b11, words hold the 2nd frame. Repeat with word_ack pulsed on each completion edge -> overrun stays 0.
- Mid-word sync: 3 bits, then sync+bit_valid with bit_in=1 -> ch_idx=1, lane0 cnt=1. Earlier partial bits are discarded; the next lane0 completion contains 1 in its first-bit position.
- Reset mid-operation: assert reset=0 asynchronously between edges with word_valid=2'b11 -> all outputs 0 immediately. After release, a full frame assembles correctly in LSB-first.
